// File: rtl/aes_key_sched_seq.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per cycle into a word store,
// round keys read through a combinational port. Optional zeroize port: AES_KEYSCHED_ZEROIZE_EN.
module aes_key_sched_seq #(
  parameter int MAX_WORDS   = 60,
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef AES_KEYSCHED_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         keys_valid,
  output logic [3:0]   num_rounds,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic [1:0]   dbg_state
);

  // Handshake: start is a single-cycle request honoured only while idle (busy=0);
  // completion is reported by a one-cycle done pulse, rejection by a one-cycle err pulse.

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EXPAND = 2'd2} state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_t         state_q, state_d;
  logic [31:0]    w [MAX_WORDS];
  logic [255:0]   key_q;
  logic [5:0]     nk_q;
  logic [3:0]     nr_q;
  logic [5:0]     cnt_q;
  logic [2:0]     j_q;
  logic [7:0]     rcon_q;
  logic           done_q, err_q, valid_q;
  logic [3:0]     nrounds_q;
  logic           zero_req;
  logic           legal, accept, reject, finish;
  logic [5:0]     last_idx;
  logic [31:0]    w_prev, w_back, sub_in, sub_out, temp;
  logic [5:0]     rd_base;

`ifdef AES_KEYSCHED_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign legal    = (key_len == 2'b00) || (key_len == 2'b01) || ((key_len == 2'b10) && SUPPORT_256);
  assign last_idx = {nr_q, 2'b11};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    finish  = 1'b0;
    if (zero_req) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (legal) begin
              accept  = 1'b1;
              state_d = LOAD;
            end else begin
              reject  = 1'b1;
            end
          end
        end
        LOAD:   state_d = EXPAND;
        EXPAND: begin
          if (cnt_q == last_idx) begin
            finish  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // j_q tracks i mod Nk so no divider is needed; rcon_q advances once per Nk words.
  assign w_prev  = w[cnt_q - 6'd1];
  assign w_back  = w[cnt_q - nk_q];
  assign sub_in  = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign sub_out = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};

  always_comb begin
    temp = w_prev;
    if (j_q == 3'd0)                          temp = sub_out ^ {rcon_q, 24'h0};
    else if ((nk_q == 6'd8) && (j_q == 3'd4)) temp = sub_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_WORDS; k++) w[k] <= '0;
      key_q     <= '0;
      nk_q      <= '0;
      nr_q      <= '0;
      cnt_q     <= '0;
      j_q       <= '0;
      rcon_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      nrounds_q <= '0;
    end else begin
      done_q <= finish;
      err_q  <= reject;
      if (zero_req) begin
        for (int k = 0; k < MAX_WORDS; k++) w[k] <= '0;
        valid_q   <= 1'b0;
        nrounds_q <= '0;
      end else begin
        if (accept) begin
          key_q   <= key_in;
          valid_q <= 1'b0;
          case (key_len)
            2'b00:   begin nk_q <= 6'd4; nr_q <= 4'd10; end
            2'b01:   begin nk_q <= 6'd6; nr_q <= 4'd12; end
            default: begin nk_q <= 6'd8; nr_q <= 4'd14; end
          endcase
        end
        if (state_q == LOAD) begin
          for (int k = 0; k < 8; k++)
            if (k < int'(nk_q)) w[k] <= key_q[255-32*k -: 32];
          cnt_q  <= nk_q;
          j_q    <= 3'd0;
          rcon_q <= 8'h01;
        end
        if (state_q == EXPAND) begin
          w[cnt_q] <= w_back ^ temp;
          cnt_q    <= cnt_q + 6'd1;
          j_q      <= (j_q == 3'(nk_q - 6'd1)) ? 3'd0 : j_q + 3'd1;
          if (j_q == 3'd0)
            rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        if (finish) begin
          valid_q   <= 1'b1;
          nrounds_q <= nr_q;
        end
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign keys_valid = valid_q;
  assign num_rounds = nrounds_q;
  assign dbg_state  = state_q;
  assign rd_base    = {rd_idx, 2'b00};

  always_comb begin
    rd_key = '0;
    if (rd_idx <= nrounds_q)
      rd_key = {w[rd_base], w[rd_base | 6'd1], w[rd_base | 6'd2], w[rd_base | 6'd3]};
  end

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Scoreboarded bench for aes_key_sched_seq: GF(2^8)-derived S-box, plain key-expansion model,
// expected done/err events queued at issue and popped by an independent monitor.
module tb_aes_key_sched_seq;

  localparam logic [1:0] K_DONE = 2'b01;
  localparam logic [1:0] K_ERR  = 2'b10;

  typedef logic [15:0][127:0] sched_t;
  typedef struct packed {
    logic [1:0]   kind;
    int           start_cyc;
    int           lat;
    logic [3:0]   nr;
    logic [4:0]   chk_idx;
    logic [127:0] chk_key;
    sched_t       rk;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, done, err, keys_valid;
  logic [3:0]   num_rounds, rd_idx;
  logic [127:0] rd_key;
  logic [1:0]   dbg_state;
`ifdef AES_KEYSCHED_ZEROIZE_EN
  logic         zeroize;
`endif

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  logic [7:0] sbox_ref [256];
  logic   m_valid = 1'b0;
  logic [3:0] m_nr = '0;
  sched_t m_rk = '0;

  aes_key_sched_seq dut (
    .clk(clk), .rst(rst),
`ifdef AES_KEYSCHED_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .err(err), .keys_valid(keys_valid),
    .num_rounds(num_rounds), .rd_idx(rd_idx), .rd_key(rd_key), .dbg_state(dbg_state)
  );

  // clock / reset
  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gf_mul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox_ref[v[31:24]], sbox_ref[v[23:16]], sbox_ref[v[15:8]], sbox_ref[v[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < n; k++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  function automatic sched_t ref_schedule(input int nk, input logic [255:0] key);
    logic [31:0] wm [60];
    logic [31:0] t;
    int nr;
    sched_t s;
    nr = nk + 6;
    s = '0;
    for (int i = 0; i < nk; i++) wm[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = wm[i-1];
      if (i % nk == 0)                 t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / nk), 24'h0};
      else if (nk == 8 && i % 8 == 4)  t = sub_word(t);
      wm[i] = wm[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) s[r] = {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]};
    return s;
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic issue(input logic [1:0] len, input logic [255:0] key,
                       input logic [4:0] chk_idx, input logic [127:0] chk_key);
    exp_t e;
    int   nk;
    e = '0;
    start = 1'b1;
    key_len = len;
    key_in = key;
    e.start_cyc = cyc + 1;
    e.chk_idx = chk_idx;
    e.chk_key = chk_key;
    if (len != 2'b11) begin
      nk = 4 + 2 * int'(len);
      e.kind = K_DONE;
      e.lat = 1 + 4 * (nk + 7) - nk;
      e.nr = 4'(nk + 6);
      e.rk = ref_schedule(nk, key);
    end else begin
      e.kind = K_ERR;
      e.lat = 0;
    end
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    key_len = 2'($urandom);
    key_in = rand_key();
    check("busy_after_start", busy, (len != 2'b11));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d expected events never seen", exp_q.size());
      exp_q.delete();
    end
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    rd_idx = 4'd0;
    forever begin
      @(negedge clk);
      if (done || err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {done, err}, 128'h0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {err, done}, e.kind);
          check("latency", cyc - e.start_cyc, e.lat);
          check("busy_at_event", busy, 1'b0);
          if (e.kind == K_DONE) begin
            check("num_rounds", num_rounds, e.nr);
            check("keys_valid_done", keys_valid, 1'b1);
            if (e.chk_idx < 5'd16) begin
              rd_idx = e.chk_idx[3:0];
              #1;
              check("known_vector", rd_key, e.chk_key);
            end
            for (int r = 0; r < 16; r++) begin
              rd_idx = 4'(r);
              #1;
              check("round_key", rd_key, e.rk[r]);
            end
            m_valid = 1'b1;
            m_nr = e.nr;
            m_rk = e.rk;
          end
        end
      end
      if (!busy && !done) begin
        check("keys_valid_idle", keys_valid, m_valid);
        check("num_rounds_idle", num_rounds, m_nr);
        rd_idx = 4'($urandom_range(0, 15));
        #1;
        check("rd_key_idle", rd_key, m_rk[rd_idx]);
      end
    end
  end

  task automatic model_clear();
    m_valid = 1'b0;
    m_nr = '0;
    m_rk = '0;
  endtask

  // stimulus
  initial begin
    rst = 1'b1;
    start = 1'b0;
    key_len = 2'b00;
    key_in = '0;
`ifdef AES_KEYSCHED_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    for (int k = 0; k < 256; k++) sbox_ref[k] = sbox_calc(8'(k));
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_keys_valid", keys_valid, 1'b0);
    check("rst_num_rounds", num_rounds, 4'd0);
    check("rst_state", dbg_state, 2'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    issue(2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 5'd10,
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    wait_idle();
    issue(2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 5'd12,
          128'he98ba06f448c773c8ecc720401002202);
    wait_idle();
    issue(2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 5'd14,
          128'hfe4890d1e6188d0b046df344706c631e);
    wait_idle();

    issue(2'b11, rand_key(), 5'd16, 128'h0);
    wait_idle();
    repeat (2) @(negedge clk);

    // starts while busy (legal and illegal) must be ignored
    issue(2'b00, rand_key(), 5'd16, 128'h0);
    repeat (14) @(negedge clk);
    start = 1'b1;
    key_len = 2'($urandom_range(0, 2));
    key_in = rand_key();
    @(negedge clk);
    key_len = 2'b11;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // asynchronous reset in the middle of an AES-256 run
    issue(2'b10, rand_key(), 5'd16, 128'h0);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    model_clear();
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_keys_valid", keys_valid, 1'b0);
    check("midrst_num_rounds", num_rounds, 4'd0);
    check("midrst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue(2'b00, rand_key(), 5'd16, 128'h0);
    wait_idle();

    // random operations, issued back to back as soon as the previous one completes
    for (int n = 0; n < 10; n++) begin
      issue(2'($urandom_range(0, 3)), rand_key(), 5'd16, 128'h0);
      wait_idle();
    end

`ifdef AES_KEYSCHED_ZEROIZE_EN
    issue(2'b01, rand_key(), 5'd16, 128'h0);
    wait_idle();
    zeroize = 1'b1;
    start = 1'b1;
    key_len = 2'b00;
    key_in = rand_key();
    @(posedge clk);
    #1;
    model_clear();
    check("zeroize_keys_valid", keys_valid, 1'b0);
    @(negedge clk);
    zeroize = 1'b0;
    start = 1'b0;
    check("zeroize_busy", busy, 1'b0);
    check("zeroize_num_rounds", num_rounds, 4'd0);
    repeat (4) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_seq.md
Name: aes_key_sched_seq

Overview:
- Iterative, clocked AES key-schedule engine for AES-128, AES-192 and AES-256, chosen per operation by `key_len`.
- Generates one 32-bit schedule word per cycle into an internal word store.
- Exposes round keys through a 128-bit combinational read port indexed by round number.
- Sits between the key register loaded over UART and the round datapath; replaces the fixed-size combinational expander to save S-box area (4 S-boxes total).

Parameters:
- MAX_WORDS, 60, depth of the word store; must be ≥ 4*(Nr+1) for the largest key length supported (60 for AES-256).
- SUPPORT_256, 1, when 0, key_len=2'b10 is rejected like an illegal code and MAX_WORDS may be 52.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle request to expand `key_in`; sampled only in IDLE.
- key_len, input, 2, 00=128 (Nk=4, Nr=10), 01=192 (Nk=6, Nr=12), 10=256 (Nk=8, Nr=14), 11=illegal.
- key_in, input, 256, cipher key, MSB-aligned: w[0]=key_in[255:224]; unused LSBs ignored.
- busy, output, 1, high from the start edge until expansion completes.
- done, output, 1, one-cycle pulse when all words are written.
- err, output, 1, one-cycle pulse when start is seen with an illegal or unsupported key_len.
- keys_valid, output, 1, store holds a complete schedule for `num_rounds`.
- num_rounds, output, 4, Nr of the stored schedule (10/12/14); 0 after reset.
- rd_idx, input, 4, round-key index.
- rd_key, output, 128, {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r=rd_idx.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, err=0, keys_valid=0, num_rounds=0; word store cleared to 0; word counter cleared.
- States: IDLE, LOAD, EXPAND.
- IDLE → LOAD: on an edge with start=1 and a legal key_len.
  - At that edge: busy←1, keys_valid←0; Nk, Nr and `key_in` are captured into internal registers.
  - Later changes to key_in or key_len have no effect.
- Illegal key_len on start: state stays IDLE, err pulses 1 cycle, keys_valid and store are unchanged.
- LOAD (1 cycle): w[0..Nk-1] written from the captured key; counter i←Nk; → EXPAND.
- EXPAND: each edge writes w[i] and increments i.
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk], 24'h0}, with Rcon = 01,02,04,08,10,20,40,80,1B,36.
  - Else if Nk==8 and i mod 8 == 4: temp = SubWord(w[i-1]).
  - w[i] = w[i-Nk] ^ temp.
  - RotWord rotates left by one byte. SubWord applies the FIPS-197 S-box per byte.
- Completion: the edge writing w[4*Nr+3] sets state←IDLE, busy←0, done←1 (cleared next edge), keys_valid←1, num_rounds←Nr.
- Latency, start edge to done high: 1+(4(Nr+1)-Nk) edges = 41 (AES-128), 47 (AES-192), 53 (AES-256).
- start while busy: ignored, with no err.
- start in the IDLE cycle right after done: accepted normally.
- rd_key is a combinational mux from the store.
  - rd_idx > num_rounds returns 128'h0.
  - Reads while busy return store contents and are undefined for round use; consumers must gate on keys_valid.
- Reset mid-expansion: everything clears immediately; no done is issued.

Optional Feature:
- Macro: AES_KEYSCHED_ZEROIZE_EN.
- When defined:
  - Adds input `zeroize` (1 bit).
  - zeroize=1 at an edge clears the whole word store and drops keys_valid to 0 in that same edge. num_rounds is also set to 0, state→IDLE, busy→0.
  - An in-flight expansion is aborted without done.
  - zeroize has priority over start in the same cycle.
- When undefined: no port is added; the store is cleared only by rst.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle → done exactly 41 edges later; num_rounds=10; rd_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6; rd_idx=0 → the key itself.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b (MSB-aligned) → done after 47 edges; rd_idx=12 → e98ba06f448c773c8ecc720401002202; rd_idx=13 → 0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done after 53 edges; rd_idx=14 → fe4890d1e6188d0b046df344706c631e.
- key_len=11 with start → err pulse 1 cycle, busy stays 0, prior keys_valid/rd_key unchanged. Then a second start pulsed mid-expansion of a valid AES-128 run → ignored; the run still finishes at edge 41 with correct keys.
- rst asserted asynchronously at edge 20 of an AES-256 run → busy/keys_valid/num_rounds=0 immediately, rd_key(0)=0, no done. A fresh AES-128 start after release completes correctly.
- (AES_KEYSCHED_ZEROIZE_EN) zeroize together with start while keys_valid=1 → keys_valid=0, rd_key(any)=0, start not accepted, busy stays 0.
